// File: rtl/dmvm_coef.sv
// dmvm_coef: streams Wh rows and computes e_j = LeakyReLU(a_src.Wh_0 + a_nbr.Wh_j), quantised per node.
// Define DMVM_SAT_EN for saturating quantisation; the default build wraps to DATA_WIDTH bits.
module dmvm_coef #(
    parameter int DATA_WIDTH      = 8,
    parameter int WH_DATA_WIDTH   = 12,
    parameter int DMVM_DATA_WIDTH = 24,
    parameter int NUM_FEATURE_OUT = 16,
    parameter int MAX_NODES       = 168,
    parameter int LRELU_SHIFT     = 2,
    parameter int COEF_SHIFT      = 3,
    localparam int NUM_NODE_WIDTH = $clog2(MAX_NODES) + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     a_rdy_i,
    input  logic [2*NUM_FEATURE_OUT*DATA_WIDTH-1:0]  a_flat_i,
    input  logic                                     wh_vld_i,
    output logic                                     wh_rdy_o,
    input  logic [NUM_FEATURE_OUT*WH_DATA_WIDTH-1:0] wh_data_i,
    input  logic [NUM_NODE_WIDTH-1:0]                wh_num_nodes_i,
    input  logic                                     wh_src_i,
    output logic                                     coef_vld_o,
    input  logic                                     coef_rdy_i,
    output logic [MAX_NODES*DATA_WIDTH-1:0]          coef_o,
    output logic [NUM_NODE_WIDTH-1:0]                num_nodes_o,
    output logic                                     err_o
);
    localparam int F   = NUM_FEATURE_OUT;
    localparam int DW  = DMVM_DATA_WIDTH;
    localparam int LVL = $clog2(F);
    localparam int NS  = LVL + 2;
    localparam int IW  = NUM_NODE_WIDTH - 1;
    localparam logic [NUM_NODE_WIDTH-1:0] N_MAX = NUM_NODE_WIDTH'(MAX_NODES);
`ifdef DMVM_SAT_EN
    localparam logic signed [DW:0] Q_MAX = (DW+1)'((2 ** (DATA_WIDTH-1)) - 1);
    localparam logic signed [DW:0] Q_MIN = ~Q_MAX;
`endif

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, OUT} state_t;
    state_t state;

    logic signed [DATA_WIDTH-1:0]    a_src [F];
    logic signed [DATA_WIDTH-1:0]    a_nbr [F];
    logic signed [WH_DATA_WIDTH-1:0] in_wh [F];
    logic signed [DW-1:0]            s_tree [2*F-1];
    logic signed [DW-1:0]            n_tree [2*F-1];
    logic signed [DW-1:0]            s0;
    logic [NS-1:0]                   vld;
    logic [IW-1:0]                   tag [NS];
    logic [DATA_WIDTH-1:0]           buf_mem [MAX_NODES];
    logic [NUM_NODE_WIDTH-1:0]       cnt, n_reg, n_eff;
    logic                            n_bad, accept, is_src, last_row;
    logic [IW-1:0]                   acc_tag;
    logic signed [DW-1:0]            s_use;
    logic signed [DW:0]              x, y, z;
    logic [DATA_WIDTH-1:0]           q;

    always_comb begin
        for (int k = 0; k < F; k++) begin
            a_src[k] = a_flat_i[k*DATA_WIDTH +: DATA_WIDTH];
            a_nbr[k] = a_flat_i[(k+F)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Row bookkeeping: a row with cnt==0 is always a source, whatever its flag says.
    always_comb begin
        accept  = wh_vld_i && wh_rdy_o;
        is_src  = (cnt == '0) || wh_src_i;
        acc_tag = is_src ? '0 : cnt[IW-1:0];
        n_bad   = 1'b0;
        n_eff   = wh_num_nodes_i;
        if (wh_num_nodes_i == '0) begin
            n_eff = NUM_NODE_WIDTH'(1);
            n_bad = 1'b1;
        end else if (wh_num_nodes_i > N_MAX) begin
            n_eff = N_MAX;
            n_bad = 1'b1;
        end
        last_row = is_src ? (n_eff == NUM_NODE_WIDTH'(1)) : (cnt == n_reg - 1'b1);
    end

    // Heap-ordered adder tree: leaves hold products, node i sums children 2i+1/2i+2 each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < F; k++) in_wh[k] <= '0;
            for (int i = 0; i < 2*F-1; i++) begin
                s_tree[i] <= '0;
                n_tree[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int k = 0; k < F; k++) in_wh[k] <= wh_data_i[k*WH_DATA_WIDTH +: WH_DATA_WIDTH];
            end
            for (int k = 0; k < F; k++) begin
                s_tree[F-1+k] <= DW'(a_src[k] * in_wh[k]);
                n_tree[F-1+k] <= DW'(a_nbr[k] * in_wh[k]);
            end
            for (int i = 0; i < F-1; i++) begin
                s_tree[i] <= s_tree[2*i+1] + s_tree[2*i+2];
                n_tree[i] <= n_tree[2*i+1] + n_tree[2*i+2];
            end
        end
    end

    always_comb begin
        s_use = (tag[NS-1] == '0) ? s_tree[0] : s0;
        x     = {s_use[DW-1], s_use} + {n_tree[0][DW-1], n_tree[0]};
        y     = x[DW] ? (x >>> LRELU_SHIFT) : x;
        z     = y >>> COEF_SHIFT;
`ifdef DMVM_SAT_EN
        if (z > Q_MAX)      q = Q_MAX[DATA_WIDTH-1:0];
        else if (z < Q_MIN) q = Q_MIN[DATA_WIDTH-1:0];
        else                q = DATA_WIDTH'(z);
`else
        q = DATA_WIDTH'(z);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wh_rdy_o   <= 1'b0;
            coef_vld_o <= 1'b0;
            err_o      <= 1'b0;
            cnt        <= '0;
            n_reg      <= '0;
            s0         <= '0;
            vld        <= '0;
            for (int s = 0; s < NS; s++) tag[s] <= '0;
            for (int j = 0; j < MAX_NODES; j++) buf_mem[j] <= '0;
        end else begin
            vld    <= {vld[NS-2:0], accept};
            tag[0] <= acc_tag;
            for (int s = 1; s < NS; s++) tag[s] <= tag[s-1];
            if (vld[NS-1]) begin
                buf_mem[tag[NS-1]] <= q;
                if (tag[NS-1] == '0) s0 <= s_tree[0];
            end
            case (state)
                IDLE: begin
                    if (a_rdy_i) begin
                        state    <= COLLECT;
                        wh_rdy_o <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        // An early source flag restarts the subgraph: flush older rows in flight.
                        if (wh_src_i && cnt != '0) begin
                            vld[NS-1:1] <= '0;
                            for (int j = 0; j < MAX_NODES; j++) buf_mem[j] <= '0;
                            err_o <= 1'b1;
                        end
                        if (is_src) begin
                            n_reg <= n_eff;
                            if (n_bad || !wh_src_i) err_o <= 1'b1;
                        end
                        if (last_row) begin
                            cnt      <= '0;
                            wh_rdy_o <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            cnt <= is_src ? NUM_NODE_WIDTH'(1) : cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (vld == '0) begin
                        state      <= OUT;
                        coef_vld_o <= 1'b1;
                    end
                end
                OUT: begin
                    if (coef_rdy_i) begin
                        for (int j = 0; j < MAX_NODES; j++) buf_mem[j] <= '0;
                        coef_vld_o <= 1'b0;
                        wh_rdy_o   <= 1'b1;
                        state      <= COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < MAX_NODES; j++) begin : g_coef
        assign coef_o[j*DATA_WIDTH +: DATA_WIDTH] = buf_mem[j];
    end

    assign num_nodes_o = n_reg;

endmodule

// File: tb/tb_dmvm_coef.sv
// tb_dmvm_coef: directed self-checking bench for dmvm_coef with hand-computed coefficients.
// Expectations for the saturation case follow the DMVM_SAT_EN macro.
module tb_dmvm_coef;
    localparam int DW   = 8;
    localparam int WW   = 12;
    localparam int F    = 16;
    localparam int MAXN = 168;
    localparam int NNW  = 9;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  a_rdy_i = 1'b0;
    logic [2*F*DW-1:0]     a_flat_i = '0;
    logic                  wh_vld_i = 1'b0;
    logic                  wh_rdy_o;
    logic [F*WW-1:0]       wh_data_i = '0;
    logic [NNW-1:0]        wh_num_nodes_i = '0;
    logic                  wh_src_i = 1'b0;
    logic                  coef_vld_o;
    logic                  coef_rdy_i = 1'b0;
    logic [MAXN*DW-1:0]    coef_o;
    logic [NNW-1:0]        num_nodes_o;
    logic                  err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int last_acc = 0;
    int n_acc    = 0;

    dmvm_coef dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_rdy_i        (a_rdy_i),
        .a_flat_i       (a_flat_i),
        .wh_vld_i       (wh_vld_i),
        .wh_rdy_o       (wh_rdy_o),
        .wh_data_i      (wh_data_i),
        .wh_num_nodes_i (wh_num_nodes_i),
        .wh_src_i       (wh_src_i),
        .coef_vld_o     (coef_vld_o),
        .coef_rdy_i     (coef_rdy_i),
        .coef_o         (coef_o),
        .num_nodes_o    (num_nodes_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] getCoef(input int j);
        return coef_o[j*DW +: DW];
    endfunction

    function automatic int countNonzero(input int from);
        int c = 0;
        for (int j = from; j < MAXN; j++) if (coef_o[j*DW +: DW] != '0) c++;
        return c;
    endfunction

    task automatic setA(input logic [DW-1:0] val);
        for (int k = 0; k < 2*F; k++) a_flat_i[k*DW +: DW] = val;
    endtask

    // Presents one row and waits (bounded) for it to be accepted.
    task automatic applyStimulus(input logic src, input int nn, input logic [WW-1:0] val);
        int guard = 0;
        wh_src_i = src;
        wh_num_nodes_i = NNW'(nn);
        for (int k = 0; k < F; k++) wh_data_i[k*WW +: WW] = val;
        wh_vld_i = 1'b1;
        while (!wh_rdy_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!wh_rdy_o) begin
            checkOutput("accept_timeout", 64'(wh_rdy_o), 64'd1);
        end else begin
            @(posedge clk); #1;
            last_acc = cycle;
            n_acc++;
        end
        wh_vld_i = 1'b0;
    endtask

    task automatic waitVld(output int lat);
        int guard = 0;
        while (!coef_vld_o && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        lat = cycle - last_acc;
        if (!coef_vld_o) checkOutput("vld_timeout", 64'(coef_vld_o), 64'd1);
    endtask

    task automatic doHandshake;
        coef_rdy_i = 1'b1;
        @(posedge clk); #1;
        coef_rdy_i = 1'b0;
    endtask

    initial begin
        int lat;
        int cnt;
        int bad;
        logic b;
        logic [MAXN*DW-1:0] snap;
        logic [NNW-1:0] snap_n;
        logic [DW-1:0] exp_sat;

        // Reset values
        #12;
        checkOutput("rst_wh_rdy", 64'(wh_rdy_o), 64'd0);
        checkOutput("rst_coef_vld", 64'(coef_vld_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        checkOutput("rst_num_nodes", 64'(num_nodes_o), 64'd0);
        checkOutput("rst_coef_zero", 64'(coef_o != '0), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stall before weights are ready
        wh_vld_i = 1'b1;
        wh_src_i = 1'b1;
        wh_num_nodes_i = 9'd2;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (wh_rdy_o) cnt++;
            @(posedge clk); #1;
        end
        checkOutput("stall_rdy_seen", 64'(cnt), 64'd0);
        wh_vld_i = 1'b0;
        setA(8'd1);
        a_rdy_i = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_to_collect", 64'(wh_rdy_o), 64'd1);

        // Basic subgraph: N=2, e0 = 8, e1 = -1
        applyStimulus(1'b1, 2, 12'd2);
        applyStimulus(1'b0, 2, 12'hFFD);
        checkOutput("basic_rdy_drop", 64'(wh_rdy_o), 64'd0);
        waitVld(lat);
        checkOutput("basic_latency", 64'(lat), 64'd7);
        checkOutput("basic_e0", 64'(getCoef(0)), 64'h08);
        checkOutput("basic_e1", 64'(getCoef(1)), 64'hFF);
        checkOutput("basic_tail_zero", 64'(countNonzero(2)), 64'd0);
        checkOutput("basic_num_nodes", 64'(num_nodes_o), 64'd2);
        checkOutput("basic_err", 64'(err_o), 64'd0);

        // Backpressure for 20 cycles with a row waiting
        snap = coef_o;
        snap_n = num_nodes_o;
        bad = 0;
        wh_vld_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (coef_o !== snap || num_nodes_o !== snap_n || wh_rdy_o !== 1'b0 || coef_vld_o !== 1'b1) bad++;
        end
        wh_vld_i = 1'b0;
        checkOutput("bp_stable", 64'(bad), 64'd0);
        doHandshake();
        checkOutput("hs_vld_drop", 64'(coef_vld_o), 64'd0);
        checkOutput("hs_back_collect", 64'(wh_rdy_o), 64'd1);
        checkOutput("hs_buffer_clear", 64'(coef_o != '0), 64'd0);

        // Saturation / wrap: a=127, wh=2047, N=1
        setA(8'd127);
        applyStimulus(1'b1, 1, 12'd2047);
        waitVld(lat);
`ifdef DMVM_SAT_EN
        exp_sat = 8'd127;
`else
        exp_sat = 8'd4;
`endif
        checkOutput("sat_latency", 64'(lat), 64'd7);
        checkOutput("sat_e0", 64'(getCoef(0)), 64'(exp_sat));
        checkOutput("sat_num_nodes", 64'(num_nodes_o), 64'd1);
        checkOutput("sat_err", 64'(err_o), 64'd0);
        doHandshake();

        // Early source flag on row 1 of N=3 restarts the subgraph
        setA(8'd1);
        applyStimulus(1'b1, 3, 12'd1);
        applyStimulus(1'b1, 3, 12'd2);
        checkOutput("badsrc_err", 64'(err_o), 64'd1);
        applyStimulus(1'b0, 3, 12'd4);
        applyStimulus(1'b0, 3, 12'hFFB);
        waitVld(lat);
        checkOutput("badsrc_latency", 64'(lat), 64'd7);
        checkOutput("badsrc_num_nodes", 64'(num_nodes_o), 64'd3);
        checkOutput("badsrc_e0", 64'(getCoef(0)), 64'h08);
        checkOutput("badsrc_e1", 64'(getCoef(1)), 64'h0C);
        checkOutput("badsrc_e2", 64'(getCoef(2)), 64'hFE);
        checkOutput("badsrc_tail_zero", 64'(countNonzero(3)), 64'd0);
        doHandshake();

        // Clamp: N=200 must accept exactly 168 rows
        wh_src_i = 1'b1;
        wh_num_nodes_i = 9'd200;
        for (int k = 0; k < F; k++) wh_data_i[k*WW +: WW] = 12'd1;
        wh_vld_i = 1'b1;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            b = wh_rdy_o;
            @(posedge clk); #1;
            if (b) begin
                cnt++;
                last_acc = cycle;
                wh_src_i = 1'b0;
            end
        end
        wh_vld_i = 1'b0;
        checkOutput("clamp_accepts", 64'(cnt), 64'd168);
        checkOutput("clamp_vld", 64'(coef_vld_o), 64'd1);
        checkOutput("clamp_num_nodes", 64'(num_nodes_o), 64'd168);
        checkOutput("clamp_err", 64'(err_o), 64'd1);
        checkOutput("clamp_e0", 64'(getCoef(0)), 64'h04);
        checkOutput("clamp_e167", 64'(getCoef(167)), 64'h04);
        doHandshake();

        // Reset in the middle of a subgraph
        applyStimulus(1'b1, 3, 12'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_wh_rdy", 64'(wh_rdy_o), 64'd0);
        checkOutput("midrst_coef_vld", 64'(coef_vld_o), 64'd0);
        checkOutput("midrst_err", 64'(err_o), 64'd0);
        checkOutput("midrst_num_nodes", 64'(num_nodes_o), 64'd0);
        checkOutput("midrst_coef_zero", 64'(coef_o != '0), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Missing source flag with N=0: treated as source with N=1
        applyStimulus(1'b0, 0, 12'd2);
        waitVld(lat);
        checkOutput("n0_latency", 64'(lat), 64'd7);
        checkOutput("n0_num_nodes", 64'(num_nodes_o), 64'd1);
        checkOutput("n0_err", 64'(err_o), 64'd1);
        checkOutput("n0_e0", 64'(getCoef(0)), 64'h08);
        doHandshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmvm_coef.md
# dmvm_coef

Attention-coefficient engine directly downstream of the attention-weight loader. Once the loader reports the 2·NUM_FEATURE_OUT attention weights ready, this block streams Wh rows for one subgraph at a time. For each node j it computes e_j = LeakyReLU(a_src·Wh_0 + a_nbr·Wh_j), where node 0 is the subgraph's source node, and quantises e_j to DATA_WIDTH. It presents the full coefficient vector to the softmax stage through a valid/ready handshake.

## Interface
- DATA_WIDTH, 8: signed width of attention weights and output coefficients.
- WH_DATA_WIDTH, 12: signed width of each Wh element.
- DMVM_DATA_WIDTH, 24: signed width of each dot-product accumulator; wraps modulo 2^DMVM_DATA_WIDTH.
- NUM_FEATURE_OUT, 16: Wh row length F; power of two, at least 2.
- MAX_NODES, 168: coefficient buffer capacity.
- LRELU_SHIFT, 2: negative-slope factor is 2^-LRELU_SHIFT, implemented as an arithmetic right shift.
- COEF_SHIFT, 3: arithmetic right shift applied before quantisation.
- NUM_NODE_WIDTH: local, $clog2(MAX_NODES)+1.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- a_rdy_i  in  1  attention weights loaded and stable.
- a_flat_i  in  2·F·DATA_WIDTH  weights. Element k occupies bits [k·DATA_WIDTH +: DATA_WIDTH]. k<F is a_src; k≥F is a_nbr.
- wh_vld_i  in  1  Wh row valid.
- wh_rdy_o  out  1  Wh row accepted when both wh_vld_i and wh_rdy_o are high.
- wh_data_i  in  F·WH_DATA_WIDTH  Wh row; element k occupies bits [k·WH_DATA_WIDTH +: WH_DATA_WIDTH].
- wh_num_nodes_i  in  NUM_NODE_WIDTH  subgraph node count N. Sampled on the source row only.
- wh_src_i  in  1  row is the source (first) node of a subgraph.
- coef_vld_o  out  1  coefficient vector valid.
- coef_rdy_i  in  1  consumer ready.
- coef_o  out  MAX_NODES·DATA_WIDTH  e_j at bits [j·DATA_WIDTH +: DATA_WIDTH]; entries j≥N are 0.
- num_nodes_o  out  NUM_NODE_WIDTH  N of the presented vector.
- err_o  out  1  sticky protocol error; cleared only by reset.

## Operation
- FSM states: IDLE, COLLECT, DRAIN, OUT.
- IDLE:
  - wh_rdy_o = 0.
  - Moves to COLLECT at the first edge where a_rdy_i = 1.
  - a_rdy_i is ignored in every other state.
- COLLECT:
  - wh_rdy_o = 1.
  - Every accepted row enters the pipeline tagged with index j, counted 0..N-1.
  - The row with j=0 latches N.
  - After the row with j=N-1 is accepted: wh_rdy_o = 0, move to DRAIN.
- DRAIN: wait until the last row's coefficient is written, then move to OUT.
- OUT:
  - coef_vld_o = 1, and coef_o / num_nodes_o are held stable.
  - On the coef_vld_o && coef_rdy_i edge: clear the buffer to 0, then return to COLLECT.
- Per row, two dot products:
  - s = Σ a_src[k]·wh[k] and n = Σ a_nbr[k]·wh[k].
  - Signed products are sign-extended to DMVM_DATA_WIDTH.
  - Adder tree of log2(F) stages; all sums wrap at DMVM_DATA_WIDTH.
- s of row j=0 is registered as s0. Row 0 itself uses its own s directly.
- Coefficient computation:
  - x = s0 + n_j, computed at DMVM_DATA_WIDTH+1 bits.
  - y = x≥0 ? x : x>>>LRELU_SHIFT.
  - z = y>>>COEF_SHIFT.
  - e_j = quant(z), written to buffer slot j.
- Boundary conditions:
  - wh_src_i = 1 with j≠0: discard the partial subgraph, clear the buffer, treat the row as a new j=0, set err_o.
  - wh_src_i = 0 with j=0: the row is still treated as the source; set err_o.
  - N = 0: treated as 1; set err_o.
  - N > MAX_NODES: clamped to MAX_NODES; set err_o.
  - Rows in flight are never dropped: wh_rdy_o falls only after the last accept.
- Reset mid-operation: FSM returns to IDLE; pipeline, buffer, counters and err_o are cleared.

## Timing
- Reset values:
  - wh_rdy_o = 0, coef_vld_o = 0, err_o = 0.
  - coef_o = 0, num_nodes_o = 0.
  - FSM in IDLE.
- A row accepted at edge T:
  - Products are registered at T+1.
  - Tree outputs are ready at T+1+log2(F); T+5 for F=16.
  - The coefficient is written at T+2+log2(F); T+6.
- With the last row accepted at edge L, coef_vld_o goes high after edge L+3+log2(F); L+7 for F=16.
- Throughput in COLLECT: one row per cycle.
- The next subgraph's first accept is no earlier than the edge after the OUT handshake.
- coef_vld_o must not drop without coef_rdy_i.
- err_o rises on the edge after the offending row is accepted.

## Configuration
- DMVM_SAT_EN:
  - Defined: quant(z) saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Undefined: quant(z) keeps the low DATA_WIDTH bits of z (wraps).

## Test plan
- Basic subgraph: a all 1, N=2. Row0 wh all 2, row1 wh all -3.
  - Expected: e0 = (32+32)>>3 = 8; e1 = ((32-48)>>>2)>>>3 = -1.
  - Entries 2..167 are 0; coef_vld_o rises 7 cycles after the last accept.
- Saturation: a all 127, wh all 2047, N=1.
  - With DMVM_SAT_EN: e0 = 127.
  - Without: e0 = 4 (low 8 bits of 1039876).
- Backpressure: hold coef_rdy_i = 0 for 20 cycles.
  - Required: coef_o and num_nodes_o stable, wh_rdy_o = 0 throughout; one handshake, then return to COLLECT.
- Bad source flag: wh_src_i = 1 on row 1 of N=3.
  - Required: err_o = 1, the subgraph restarts, and the output holds 3 coefficients computed from the new source.
- Stall before ready: wh_vld_i high while a_rdy_i = 0 for 10 cycles.
  - Required: wh_rdy_o = 0 and no accept. Assert rst_n mid-COLLECT: all outputs return to reset values.
- Clamp: N = 200.
  - Required: num_nodes_o = 168, err_o = 1, exactly 168 rows accepted.
